bin2bcd_seq_ctrl: RTL and testbench
===================================

// Module: bin2bcd_seq_ctrl
// PURPOSE
//  Sequential binary-to-BCD converter: accepts one W-bit binary word over a valid/ready
//  handshake and runs one shift-add-3 (double-dabble) iteration per clock. It presents
//  the D-digit packed BCD result over a second valid/ready handshake.
//  It sits between a binary producer (counter, ADC, register) and a BCD display/driver.
//  It replaces a wide combinational converter with one-digit-row logic.
// PARAMETERS
//  W  8  binary input width, >= 2
//  D  3  BCD digits out; must satisfy 10**D > 2**W - 1 (elaboration-time check, $error)
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    in_data valid
//  in_ready   out  1    converter can accept (high only in IDLE)
//  in_data    in   W    binary value (unsigned; two's complement with BCD_SIGN_EN)
//  out_valid  out  1    out_bcd/out_neg valid, held until out_ready
//  out_ready  in   1    consumer accepts result
//  out_bcd    out  4*D  packed BCD, digit 0 (ones) in [3:0]
//  out_neg    out  1    result negative (always 0 without BCD_SIGN_EN)
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0 while rst_n low, 1 the first cycle after release;
//    out_valid=0, out_bcd=0, out_neg=0, bit counter=0, shift reg=0.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready edge: shift reg<=in_data (magnitude, see opt.),
//    bcd<=0, cnt<=W, go SHIFT. in_data is ignored at all other times.
//  - SHIFT: in_ready=0. Each edge: every digit >=5 gets +3 (4-bit, no carry out of digit).
//    Then shift {bcd,sr} left 1 and cnt<=cnt-1. When cnt==1 at the edge, go DONE.
//    Exactly W SHIFT edges.
//  - Latency: out_valid rises W clocks after the accept edge (8 for W=8).
//  - DONE: out_valid=1, out_bcd/out_neg stable. On out_ready edge go IDLE; out_valid=0 next.
//    out_ready while not DONE is ignored.
//  - No overlap: a new input is never accepted in SHIFT or DONE, even with
//    out_ready=1. Minimum period is W+2 clocks.
//  - Backpressure: DONE is held indefinitely; outputs must not change while out_valid=1 && !out_ready.
//  - Reset mid-operation (any state): immediate abort to reset values. The partial result
//    is discarded and never presented.
//  - out_bcd holds its last value after leaving DONE until the next result is loaded. It is meaningful only with out_valid.
//  - Counter width $clog2(W+1); no wrap, because cnt never decrements below 1 in SHIFT.
// CONFIGURATION
//  BCD_SIGN_EN defined:
//    in_data is two's complement.
//    At the accept edge: if in_data[W-1]=1, the shift reg loads -in_data as W-bit unsigned,
//    so -2**(W-1) maps to 2**(W-1), and out_neg<=1; otherwise out_neg<=0.
//    Sign capacity check uses 10**D > 2**(W-1).
//  BCD_SIGN_EN undefined:
//    in_data is unsigned; out_neg constant 0.
//  Latency is identical either way.
// STRUCTURE
//  - Package bcd_pkg: state enum bcd_state_t {IDLE,SHIFT,DONE}; localparam ADD3_THRESH=4'd5,
//    ADD3_VAL=4'd3; function digits_ok(W,D) for the capacity check.
//  - Sub-module bcd_dabble_step (combinational, params W,D): in {bcd,sr} -> adjusted+shifted
//    {bcd,sr}. It is instantiated once; the FSM and handshake registers live in the top module.
// TESTING (W=8, D=3)
//  1. in_data=8'd255 accepted, out_ready=1 -> out_valid exactly 8 clks after accept,
//     out_bcd=12'h255; IDLE again after 1 clk.
//  2. in_data=0, then 8'd99, then 8'd100 back-to-back -> results 12'h000, 12'h099, 12'h100.
//     in_ready is low throughout SHIFT/DONE.
//  3. Backpressure: 8'd173, out_ready=0 for 20 clks -> out_valid=1 and out_bcd=12'h173 stable.
//     A second in_valid is not accepted until 1 clk after out_ready.
//  4. Reset: rst_n low 4 clks into SHIFT -> out_valid=0, out_bcd=0 asynchronously. Next
//     conversion of 8'd42 -> 12'h042 with normal latency.
//  5. Exhaustive 0..255 vs reference model with random out_ready stalls -> every result matches.
//  6. BCD_SIGN_EN: 8'h80 -> out_neg=1, 12'h128. 8'hFF -> out_neg=1, 12'h001.
//     8'h7F -> out_neg=0, 12'h127.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL = 4'd3;
  function automatic bit digits_ok(input int w, input int d, input bit sgn);
    longint p;
    longint lim;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    lim = sgn ? (longint'(1) << (w - 1)) : (longint'(1) << w) - 1;
    return p > lim;
  endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration, add-3 on every digit >= 5 then shift {bcd,sr} left.
module bcd_dabble_step import bcd_pkg::*; #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic [4*D+W-1:0] din,
  output logic [4*D+W-1:0] dout
);
  logic [4*D-1:0] adj;
  for (genvar g = 0; g < D; g++) begin : g_dig
    assign adj[4*g+:4] = din[W+4*g+:4] >= ADD3_THRESH ? din[W+4*g+:4] + ADD3_VAL : din[W+4*g+:4];
  end
  assign dout = {adj, din[W-1:0]} << 1;
endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: valid/ready sequential binary-to-BCD converter, one dabble step per clock.
// Define BCD_SIGN_EN to treat in_data as two's complement and report the sign on out_neg.
module bin2bcd_seq_ctrl import bcd_pkg::*; #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] out_bcd,
  output logic           out_neg
);
  localparam int CW = $clog2(W + 1);
`ifdef BCD_SIGN_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  if (!digits_ok(W, D, SGN)) begin : g_cap
    $error("bin2bcd_seq_ctrl: D too small for W");
  end
  bcd_state_t state;
  logic [CW-1:0] cnt;
  logic [4*D-1:0] bcd;
  logic [W-1:0] sr;
  logic [W-1:0] mag;
  logic neg;
  logic [4*D+W-1:0] nxt;
  bcd_dabble_step #(.W(W), .D(D)) u_step (.din({bcd, sr}), .dout(nxt));
`ifdef BCD_SIGN_EN
  // -(-2**(W-1)) wraps to itself, which read as unsigned is the correct magnitude
  assign neg = in_data[W-1];
  assign mag = neg ? -in_data : in_data;
`else
  assign neg = 1'b0;
  assign mag = in_data;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_bcd <= '0;
      out_neg <= 1'b0;
      cnt <= '0;
      bcd <= '0;
      sr <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sr <= mag;
            bcd <= '0;
            cnt <= CW'(W);
            out_neg <= neg;
            in_ready <= 1'b0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, sr} <= nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out_bcd <= nxt[4*D+W-1:W];
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// tb_bin2bcd_seq_ctrl: randomized self-checking bench for bin2bcd_seq_ctrl (W=8, D=3).
module tb_bin2bcd_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [11:0] out_bcd;
  logic out_neg;
  int checks = 0;
  int errors = 0;

  bin2bcd_seq_ctrl #(.W(8), .D(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_neg(out_neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [12:0] ref_model(input logic [7:0] v);
    int m;
    bit n;
    m = int'(v);
    n = 1'b0;
`ifdef BCD_SIGN_EN
    if (v[7]) begin
      n = 1'b1;
      m = 256 - m;
    end
`endif
    return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic start(input logic [7:0] v);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data = v;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic finish(input logic [7:0] v, input int stall);
    int lat;
    logic [12:0] exp;
    exp = ref_model(v);
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk("busy_in_ready", in_ready, 0);
      out_ready = 1'($urandom);
      in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", lat, 8);
    chk("bcd", out_bcd, exp[11:0]);
    chk("neg", out_neg, exp[12]);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_bcd", out_bcd, exp[11:0]);
      chk("stall_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'($urandom);
    chk("valid_drop", out_valid, 0);
    chk("idle_again", in_ready, 1);
    chk("bcd_hold", out_bcd, exp[11:0]);
  endtask

  task automatic run(input logic [7:0] v, input int stall);
    start(v);
    finish(v, stall);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", out_bcd, 0);
    chk("rst_neg", out_neg, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    run(8'd255, 0);
    run(8'd0, 0);
    run(8'd99, 0);
    run(8'd100, 0);
    run(8'd173, 20);
    start(8'd200);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_bcd", out_bcd, 0);
    chk("arst_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(8'd42, 0);
    for (int i = 0; i < 256; i++) run(8'(i), $urandom_range(0, 3));
`ifdef BCD_SIGN_EN
    run(8'h80, 1);
    run(8'hFF, 0);
    run(8'h7F, 2);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
